// File: rtl/acc_trace_pkg.sv
// Shared types and helpers for the accumulator trace UART: UART FSM states,
// frame width and the nibble-to-ASCII-hex conversion.
package acc_trace_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int DATA_BITS = 8;

    // '0'..'9' for 0-9, 'A'..'F' for 10-15
    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
        logic [7:0] wide;
        wide = {4'h0, nib};
        if (nib < 4'd10) begin
            return 8'h30 + wide;
        end
        return 8'h41 + (wide - 8'd10);
    endfunction

endpackage

// File: rtl/acc_trace_uart_tx.sv
// 8N1 UART transmitter, LSB first. Accepts a byte only in IDLE (ready=1);
// tx is registered from the state held before each edge, so it lags by one cycle.
module uart_tx
    import acc_trace_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       valid,
    input  logic [7:0] data,
    output logic       ready,
    output logic       tx
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] BIT_LAST  = IW'(DATA_BITS - 1);

    uart_state_t          state_q;
    logic [BW-1:0]        baud_cnt_q;
    logic [IW-1:0]        bit_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 tx_q;

    logic baud_done;
    assign baud_done = (baud_cnt_q == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
        end else begin
            case (state_q)
                START:   tx_q <= 1'b0;
                DATA:    tx_q <= shift_q[bit_idx_q];
                default: tx_q <= 1'b1;
            endcase

            case (state_q)
                IDLE: begin
                    if (valid) begin
                        shift_q    <= data;
                        baud_cnt_q <= '0;
                        state_q    <= START;
                    end
                end
                START: begin
                    if (baud_done) begin
                        baud_cnt_q <= '0;
                        bit_idx_q  <= '0;
                        state_q    <= DATA;
                    end else begin
                        baud_cnt_q <= baud_cnt_q + BW'(1);
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        baud_cnt_q <= '0;
                        if (bit_idx_q == BIT_LAST) begin
                            state_q <= STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + IW'(1);
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + BW'(1);
                    end
                end
                STOP: begin
                    if (baud_done) begin
                        baud_cnt_q <= '0;
                        state_q    <= IDLE;
                    end else begin
                        baud_cnt_q <= baud_cnt_q + BW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ready = (state_q == IDLE);
    assign tx    = tx_q;

endmodule

// File: rtl/acc_trace_uart.sv
// Accumulator change tracer: queues every sampled change of acc_in in a small
// FIFO and sends each as an ASCII hex character over the UART.
module acc_trace_uart
    import acc_trace_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          sample_en,
    input  logic [3:0]                    acc_in,
    output logic                          tx,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;

    logic [3:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [LW-1:0] level_q;
    logic [LW-1:0] level_d;
    logic [3:0]    prev_q;
    logic          prev_valid_q;
    logic          overflow_q;

    logic       push_req;
    logic       fifo_full;
    logic       fifo_nonempty;
    logic       push;
    logic       pop;
    logic       tx_ready;
    logic [7:0] head_ascii;

    assign push_req      = sample_en && (!prev_valid_q || (acc_in != prev_q));
    // Fullness uses the registered level, so a same-cycle pop cannot rescue a push.
    assign fifo_full     = (level_q == LW'(FIFO_DEPTH));
    assign fifo_nonempty = (level_q != '0);
    assign push          = push_req && !fifo_full;
    assign pop           = fifo_nonempty && tx_ready;
    assign level_d       = level_q + LW'(push) - LW'(pop);
    assign head_ascii    = nibble_to_ascii(mem_q[rd_ptr_q]);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            if (sample_en) begin
                prev_q       <= acc_in;
                prev_valid_q <= 1'b1;
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            level_q <= level_d;
            if (push_req && fifo_full) begin
                overflow_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= acc_in;
        end
    end

    uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk    (clk),
        .resetn (resetn),
        .valid  (fifo_nonempty),
        .data   (head_ascii),
        .ready  (tx_ready),
        .tx     (tx)
    );

    assign busy       = !tx_ready || fifo_nonempty;
    assign overflow   = overflow_q;
    assign fifo_level = level_q;

endmodule

// File: doc/acc_trace_uart.md
Name: acc_trace_uart

Overview:
- Downstream observer of the accumulator machine: watches its 4-bit accumulator output and reports every value change over a UART serial line.
- Each change is pushed into a small FIFO, converted to an ASCII hex character ('0'-'9', 'A'-'F') and transmitted 8N1, LSB first.
- Used for board-level tracing of program execution without a logic analyser.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); legal range ≥ 2.
- FIFO_DEPTH, 8, trace FIFO entries; power of two, ≥ 2.

Ports:
- clk  input  1  system clock, rising edge.
- resetn  input  1  synchronous active-low reset.
- sample_en  input  1  when high, acc_in is compared and may be captured this cycle.
- acc_in  input  4  accumulator value from the accumulator machine.
- tx  output  1  UART serial out, idle high.
- busy  output  1  high while a frame is in progress or the FIFO is non-empty.
- overflow  output  1  sticky: a change was dropped because the FIFO was full.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (resetn=0 at a clk edge) gives: tx=1, busy=0, overflow=0, fifo_level=0, UART state IDLE, prev_valid=0, prev=0. Reset mid-frame aborts the frame; tx returns high on the next edge.
- Change detect: on a clk edge with sample_en=1, a push is requested if prev_valid=0 or acc_in≠prev. prev is then loaded with acc_in and prev_valid is set to 1.
  - The first sampled value after reset is therefore always reported.
  - sample_en=0 means no compare and no update.
- Push: the 4-bit value is written at the FIFO write pointer. fifo_level increments on the following edge, so capture-to-level latency is 1 cycle.
- Full FIFO: a push request while fifo_level==FIFO_DEPTH is dropped and overflow is set.
  - Fullness is evaluated before any same-cycle pop, so a drop still occurs when a pop happens in the same cycle.
  - overflow clears only on reset.
- Pointers are log2(FIFO_DEPTH) bits wide and wrap naturally.
- Simultaneous push+pop when not full: level is unchanged and both are performed.
- ASCII mapping: nibble 0-9 → 8'h30+n; nibble 10-15 → 8'h41+(n-10).
- UART FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If FIFO non-empty, pop the head, load the ASCII byte into the shift register, clear baud_cnt, and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
  - DATA: tx=shift[bit_idx] for CLKS_PER_BIT cycles per bit, bit_idx 0..7, then go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Frame length is exactly 10×CLKS_PER_BIT cycles from the first cycle tx=0 to the end of the stop bit.
- Back-to-back frames have a 1-cycle IDLE gap (tx=1) between the stop bit and the next start bit.
- First frame latency: sampled change at edge N gives push at N, pop at N+1 (IDLE sees non-empty), and tx=0 from edge N+2.
- baud_cnt counts 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT); terminal count advances the bit.
- busy = (state≠IDLE) | (fifo_level≠0).
- tx is registered, with no combinational path from inputs.

Decomposition:
- Package acc_trace_pkg holds:
  - typedef enum logic [1:0] uart_state_t {IDLE, START, DATA, STOP}
  - localparam DATA_BITS=8
  - function nibble_to_ascii(logic [3:0]) returning logic [7:0]
- One natural sub-module: uart_tx (CLKS_PER_BIT parameter; ports clk, resetn, valid, data[7:0], ready, tx), with ready=1 only in IDLE.
- The FIFO and change detector stay in acc_trace_uart.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4 in sim):
- Reset then sample_en=1, acc_in=4'h0 held → exactly one frame: tx low at cycle 2 after first sample, bits LSB-first of 8'h30 (0,0,0,0,1,1,0,0), stop high; 40 cycles; no further frames.
- acc_in steps 4'h0→4'hA→4'hF on three consecutive sampled cycles → frames 8'h30, 8'h41, 8'h46 in order, 1-cycle gaps; fifo_level peaks at 2; busy drops after the last stop bit.
- Six distinct values on consecutive cycles with the FIFO draining slowly → fifo_level reaches 4 and overflow=1; only the first five values (one popped) are transmitted; overflow stays 1.
- acc_in toggles while sample_en=0, then sample_en=1 with acc_in equal to the last sampled value → no push and tx stays 1.
- resetn=0 asserted during DATA bit 3 → next edge tx=1, busy=0, fifo_level=0, overflow=0; after release the first sampled value is transmitted again.
- Simultaneous push and pop at fifo_level=4 → push dropped, overflow set, level becomes 3.
